// File: rtl/bram_fifo_ctrl_pkg.sv
// Shared memory constants for BRAM-backed FIFO controllers.
package bram_fifo_ctrl_pkg;
   localparam int RD_LATENCY = 1;                     // BRAM read data returns this many cycles after enable
   localparam int BUF_DEPTH  = 2;                     // output buffer entries
   localparam int BUF_CNT_W  = $clog2(BUF_DEPTH + 1); // width of the output buffer occupancy
endpackage

// File: rtl/bram_fifo_ctrl_skid_buffer_2.sv
// Two-entry in-order output buffer; slot[0] is always the word presented downstream.
module skid_buffer_2
   import bram_fifo_ctrl_pkg::*;
#(
   parameter int p_DATA_WIDTH = 8
) (
   input  logic                    i_CLK,
   input  logic                    i_RST_N,
   input  logic                    i_PUSH,
   input  logic [p_DATA_WIDTH-1:0] i_DATA,
   input  logic                    i_POP,
   output logic                    o_VALID,
   output logic [p_DATA_WIDTH-1:0] o_DATA,
   output logic [BUF_CNT_W-1:0]    o_COUNT
);
   logic [BUF_DEPTH-1:0][p_DATA_WIDTH-1:0] slot;
   logic [BUF_CNT_W-1:0]                   cnt;

   // Shift on pop, fill the first free slot on push; the caller never pushes into a full buffer.
   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         slot <= '0;
         cnt  <= '0;
      end else begin
         case ({i_PUSH, i_POP})
            2'b10: begin
               if (cnt == '0) slot[0] <= i_DATA;
               else           slot[1] <= i_DATA;
               cnt <= cnt + BUF_CNT_W'(1);
            end
            2'b01: begin
               slot[0] <= slot[1];
               cnt     <= cnt - BUF_CNT_W'(1);
            end
            2'b11: begin
               if (cnt == BUF_CNT_W'(1)) begin
                  slot[0] <= i_DATA;
               end else begin
                  slot[0] <= slot[1];
                  slot[1] <= i_DATA;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_VALID = (cnt != '0);
   assign o_DATA  = slot[0];
   assign o_COUNT = cnt;
endmodule

// File: rtl/bram_fifo_ctrl.sv
// FIFO controller around an external dual-port BRAM with a 2-entry output buffer
// that hides the BRAM read latency and sustains one word per cycle.
module bram_fifo_ctrl
   import bram_fifo_ctrl_pkg::*;
#(
   parameter int p_ADDRESS_WIDTH = 4,
   parameter int p_DATA_WIDTH    = 8
) (
   input  logic                       i_CLK,
   input  logic                       i_RST_N,
   input  logic                       i_WRITE_VALID,
   input  logic [p_DATA_WIDTH-1:0]    i_WRITE_DATA,
   output logic                       o_WRITE_READY,
   output logic                       o_READ_VALID,
   output logic [p_DATA_WIDTH-1:0]    o_READ_DATA,
   input  logic                       i_READ_READY,
   output logic                       o_RAM_WRITE_ENABLE,
   output logic [p_ADDRESS_WIDTH-1:0] o_RAM_WRITE_ADDRESS,
   output logic [p_DATA_WIDTH-1:0]    o_RAM_WRITE_DATA,
   output logic                       o_RAM_READ_ENABLE,
   output logic [p_ADDRESS_WIDTH-1:0] o_RAM_READ_ADDRESS,
   input  logic [p_DATA_WIDTH-1:0]    i_RAM_READ_DATA,
   output logic                       o_FULL,
   output logic                       o_EMPTY,
   output logic [p_ADDRESS_WIDTH+1:0] o_COUNT
);
   localparam int D  = 2 ** p_ADDRESS_WIDTH;
   localparam int MW = p_ADDRESS_WIDTH + 1;
   localparam int CW = p_ADDRESS_WIDTH + 2;

   logic [p_ADDRESS_WIDTH-1:0] wr_ptr, rd_ptr;
   logic [MW-1:0]              mem_cnt;
   logic [RD_LATENCY-1:0]      rd_pipe;
   logic [BUF_CNT_W-1:0]       buf_cnt;
   logic [CW-1:0]              inflight;
   logic                       push, pop, rd_issue, rd_capture, out_valid;

   // Full only looks at the memory, so a same-cycle read issue never lets a write through.
   assign o_FULL        = (mem_cnt == MW'(D));
   assign o_WRITE_READY = !o_FULL;
   assign push          = i_WRITE_VALID && o_WRITE_READY;
   assign pop           = out_valid && i_READ_READY;
   assign rd_capture    = rd_pipe[RD_LATENCY-1];

   // Issue a read only if its word is guaranteed a buffer slot on return.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(rd_pipe[i]);
      rd_issue = (mem_cnt != '0) &&
                 ((CW'(buf_cnt) + inflight) < (CW'(BUF_DEPTH) + CW'(pop)));
   end

   assign o_RAM_WRITE_ENABLE  = push;
   assign o_RAM_WRITE_ADDRESS = wr_ptr;
   assign o_RAM_WRITE_DATA    = i_WRITE_DATA;
   assign o_RAM_READ_ENABLE   = rd_issue;
   assign o_RAM_READ_ADDRESS  = rd_ptr;

   // Pointers wrap naturally at D; memory count and read-valid pipeline track issued reads.
   always_ff @(posedge i_CLK or negedge i_RST_N) begin
      if (!i_RST_N) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         mem_cnt <= '0;
         rd_pipe <= '0;
      end else begin
         if (push)     wr_ptr <= wr_ptr + p_ADDRESS_WIDTH'(1);
         if (rd_issue) rd_ptr <= rd_ptr + p_ADDRESS_WIDTH'(1);
         mem_cnt    <= mem_cnt + MW'(push) - MW'(rd_issue);
         rd_pipe[0] <= rd_issue;
         for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
      end
   end

   skid_buffer_2 #(.p_DATA_WIDTH(p_DATA_WIDTH)) u_out_buf (
      .i_CLK   (i_CLK),
      .i_RST_N (i_RST_N),
      .i_PUSH  (rd_capture),
      .i_DATA  (i_RAM_READ_DATA),
      .i_POP   (pop),
      .o_VALID (out_valid),
      .o_DATA  (o_READ_DATA),
      .o_COUNT (buf_cnt)
   );

   assign o_READ_VALID = out_valid;
   assign o_COUNT      = CW'(mem_cnt) + inflight + CW'(buf_cnt);
   assign o_EMPTY      = (o_COUNT == '0);
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed + randomized bench for bram_fifo_ctrl against an occupancy/queue reference model.
module tb_bram_fifo_ctrl;
   localparam int AW = 4;
   localparam int DW = 8;
   localparam int D  = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wvalid = 1'b0, rready = 1'b0;
   logic [DW-1:0] wdata = '0;
   logic          wready, rvalid, ram_we, ram_re, full, empty;
   logic [DW-1:0] rdata, ram_wd, ram_rd;
   logic [AW-1:0] ram_wa, ram_ra;
   logic [AW+1:0] count;

   always #5 clk = ~clk;

   bram_fifo_ctrl #(.p_ADDRESS_WIDTH(AW), .p_DATA_WIDTH(DW)) dut (
      .i_CLK(clk), .i_RST_N(rst_n),
      .i_WRITE_VALID(wvalid), .i_WRITE_DATA(wdata), .o_WRITE_READY(wready),
      .o_READ_VALID(rvalid), .o_READ_DATA(rdata), .i_READ_READY(rready),
      .o_RAM_WRITE_ENABLE(ram_we), .o_RAM_WRITE_ADDRESS(ram_wa), .o_RAM_WRITE_DATA(ram_wd),
      .o_RAM_READ_ENABLE(ram_re), .o_RAM_READ_ADDRESS(ram_ra), .i_RAM_READ_DATA(ram_rd),
      .o_FULL(full), .o_EMPTY(empty), .o_COUNT(count)
   );

   // Dual-port BRAM stand-in: 1-cycle registered read, zeros when not enabled.
   logic [DW-1:0] bram [D];
   always @(posedge clk) begin
      if (ram_we) bram[ram_wa] <= ram_wd;
      ram_rd <= ram_re ? bram[ram_ra] : '0;
   end

   int checks = 0, errors = 0, pops = 0;
   // reference model: memory words m, in-flight reads f, buffered words b, pointers, data queue
   int m = 0, f = 0, b = 0, wp = 0, rp = 0;
   logic [DW-1:0] q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m = 0; f = 0; b = 0; wp = 0; rp = 0;
      q.delete();
   endtask

   task automatic step(input bit wv, input logic [DW-1:0] wd, input bit rr);
      bit e_push, e_pop, e_issue;
      @(negedge clk);
      wvalid = wv; wdata = wd; rready = rr;
      #1;
      e_push  = wv && (m < D);
      e_pop   = (b > 0) && rr;
      e_issue = (m > 0) && ((b + f - int'(e_pop)) < 2);
      chk("wready", wready, m < D);
      chk("full",   full,   m == D);
      chk("count",  count,  m + f + b);
      chk("empty",  empty,  (m + f + b) == 0);
      chk("rvalid", rvalid, b > 0);
      if (b > 0) chk("rdata", rdata, q[0]);
      chk("ram_we", ram_we, e_push);
      if (e_push) begin
         chk("ram_wa", ram_wa, wp);
         chk("ram_wd", ram_wd, wd);
      end
      chk("ram_re", ram_re, e_issue);
      if (e_issue) chk("ram_ra", ram_ra, rp);
      @(posedge clk);
      if (e_push) begin q.push_back(wd); wp = (wp + 1) % D; end
      if (e_pop)  begin void'(q.pop_front()); pops++; end
      if (e_issue) rp = (rp + 1) % D;
      b = b - int'(e_pop) + f;
      f = int'(e_issue);
      m = m + int'(e_push) - int'(e_issue);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_rvalid"}, rvalid, 0);
      chk({tag, "_rdata"},  rdata,  0);
      chk({tag, "_full"},   full,   0);
      chk({tag, "_empty"},  empty,  1);
      chk({tag, "_count"},  count,  0);
      chk({tag, "_wready"}, wready, 1);
      chk({tag, "_ram_we"}, ram_we, 0);
      chk({tag, "_ram_re"}, ram_re, 0);
   endtask

   initial begin
      logic [DW-1:0] held;
      bit wv, rr;

      // reset state
      #3;
      chk_reset_vals("rst");
      @(negedge clk); rst_n = 1'b1;

      // single word latency: visible 3 edges after the push, then empty again
      step(1, 8'h11, 1);
      step(0, 8'h00, 1);
      step(0, 8'h00, 0);
      #1;
      chk("lat3_valid", rvalid, 1);
      chk("lat3_data",  rdata,  8'h11);
      step(0, 8'h00, 1);
      #1;
      chk("lat3_empty", empty, 1);

      // fill: 18 words accepted, 19th stalls
      for (int i = 0; i < 19; i++) step(1, 8'(i), 0);
      #1;
      chk("fill_wready", wready, 0);
      chk("fill_full",   full,   1);
      chk("fill_count",  count,  18);

      // push+pop at full: push rejected, room next cycle
      step(1, 8'hEE, 1);
      #1;
      chk("fullpp_wready", wready, 1);
      chk("fullpp_count",  count,  17);

      repeat (20) step(0, 8'h00, 1);
      #1;
      chk("drain_empty", empty, 1);

      // streaming: 40 words, one per cycle after 3 cycles of priming
      pops = 0;
      for (int i = 0; i < 43; i++) step(i < 40, 8'(8'h80 + i), 1);
      #1;
      chk("stream_pops",  pops,  40);
      chk("stream_empty", empty, 1);

      // back-pressure: data held, no extra reads while the buffer is full
      step(1, 8'h5A, 0);
      step(1, 8'h5B, 0);
      step(1, 8'h5C, 0);
      step(0, 8'h00, 0);
      #1;
      held = rdata;
      chk("bp_valid", rvalid, 1);
      repeat (5) step(0, 8'h00, 0);
      #1;
      chk("bp_hold", rdata, held);
      chk("bp_count", count, 3);
      repeat (6) step(0, 8'h00, 1);

      // randomized traffic: fill-biased then drain-biased
      for (int i = 0; i < 400; i++) begin
         wv = ($urandom_range(0, 99) < ((i < 200) ? 75 : 30));
         rr = ($urandom_range(0, 99) < ((i < 200) ? 35 : 80));
         step(wv, 8'($urandom), rr);
      end

      // reset mid-operation with a read in flight and buffered words
      repeat (4) step(1, 8'($urandom_range(0, 8'h9F)), 0);
      step(0, 8'h00, 1);
      #2;
      wvalid = 1'b0; rready = 1'b0;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      @(negedge clk); rst_n = 1'b1;
      model_reset();
      step(1, 8'hA5, 0);
      step(0, 8'h00, 0);
      step(0, 8'h00, 0);
      #1;
      chk("postrst_valid", rvalid, 1);
      chk("postrst_data",  rdata,  8'hA5);
      chk("postrst_count", count,  1);
      repeat (3) step(0, 8'h00, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
